// File: rtl/sdrd_pkg.sv
// Shared types and constants for the SDRD serial port controller.
// Imported by the controller and the shift engine.
package sdrd_pkg;

    localparam int CMD_BITS_DEF  = 4;
    localparam int DATA_BITS_DEF = 6;

    localparam logic WIN_BA13 = 1'b0;
    localparam logic WIN_BA12 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DATA,
        DONE,
        ACK,
        WAIT_REL
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_POLL
    } owner_t;

endpackage

// File: rtl/sdrd_shift.sv
// Serial bit engine: bit timer, bit counter, command shift-out,
// data shift-in and sclk/sdo generation for one SDRD frame.
module sdrd_shift
    import sdrd_pkg::*;
#(
    parameter int CMD_BITS  = CMD_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int DIV       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 run,
    input  logic [CMD_BITS-1:0]  cmd,
    input  logic                 sdrd,
    output logic                 sclk,
    output logic                 sdo,
    output logic                 phase,
    output logic                 cmd_last,
    output logic                 last_bit,
    output logic [DATA_BITS-1:0] rx_data
);

    localparam int TOT = CMD_BITS + DATA_BITS;
    localparam int DW  = $clog2(DIV);
    localparam int BW  = $clog2(TOT);

    logic [DW-1:0]        div_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [CMD_BITS-1:0]  cmd_sr;
    logic [DATA_BITS-1:0] data_sr;
    logic                 in_cmd;

    assign in_cmd   = bit_cnt < BW'(CMD_BITS);
    assign phase    = run & (div_cnt == DW'(DIV - 1));
    assign cmd_last = bit_cnt == BW'(CMD_BITS - 1);
    assign last_bit = bit_cnt == BW'(TOT - 1);
    assign sclk     = run & (div_cnt >= DW'(DIV / 2));
    assign sdo      = run & in_cmd & cmd_sr[CMD_BITS-1];
    assign rx_data  = {data_sr[DATA_BITS-2:0], sdrd};

    // Advance the bit timer; shift command out or data in at each bit end.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            cmd_sr  <= '0;
            data_sr <= '0;
        end else if (start) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            cmd_sr  <= cmd;
            data_sr <= '0;
        end else if (run) begin
            if (phase) begin
                div_cnt <= '0;
                bit_cnt <= bit_cnt + 1'b1;
                if (in_cmd) begin
                    cmd_sr <= {cmd_sr[CMD_BITS-2:0], 1'b0};
                end else begin
                    data_sr <= rx_data;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdrd_serial_ctrl.sv
// SDRD port sequencer: arbitrates host bus and poller, runs one
// serial frame per grant and returns the result to the winner.
module sdrd_serial_ctrl
    import sdrd_pkg::*;
#(
    parameter int CMD_BITS   = CMD_BITS_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int DIV        = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sser_n,
    input  logic                 ba13,
    input  logic                 ba12,
    input  logic [CMD_BITS-1:0]  ba_cmd,
    input  logic                 br_w,
    output logic [DATA_BITS-1:0] cpu_rdata,
    output logic                 cpu_dtack,
    input  logic                 poll_req,
    input  logic [CMD_BITS-1:0]  poll_cmd,
    output logic                 poll_gnt,
    output logic                 poll_done,
    output logic [DATA_BITS-1:0] poll_data,
    output logic                 scs,
    output logic                 sclk,
    output logic                 sdo,
    input  logic                 sdrd,
    output logic                 busy
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    state_t               state;
    owner_t               owner;
    logic                 aband;
    logic [SW-1:0]        starve_cnt;
    logic                 hit;
    logic                 rd_hit;
    logic                 wr_hit;
    logic                 starved;
    logic                 idle;
    logic                 cpu_start;
    logic                 poll_start;
    logic                 start;
    logic                 run;
    logic [CMD_BITS-1:0]  start_cmd;
    logic                 phase;
    logic                 cmd_last;
    logic                 last_bit;
    logic [DATA_BITS-1:0] rx_data;

    assign hit     = ~sser_n & (ba13 == WIN_BA13) & (ba12 == WIN_BA12);
    assign rd_hit  = hit & br_w;
    assign wr_hit  = hit & ~br_w;
    assign starved = starve_cnt == SW'(STARVE_LIM);
    assign idle    = state == IDLE;

    assign cpu_start  = idle & rd_hit & ~(poll_req & starved);
    assign poll_start = idle & poll_req & ~wr_hit & ~cpu_start;
    assign start      = cpu_start | poll_start;
    assign start_cmd  = poll_start ? poll_cmd : ba_cmd;

    assign run  = (state == CMD) | (state == DATA);
    assign scs  = run;
    assign busy = ~idle;

    assign cpu_dtack = (state == ACK) |
                       ((state == DONE) & (owner == OWN_CPU) & ~aband);
    assign poll_done = (state == DONE) & (owner == OWN_POLL);

    sdrd_shift #(
        .CMD_BITS  (CMD_BITS),
        .DATA_BITS (DATA_BITS),
        .DIV       (DIV)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .run      (run),
        .cmd      (start_cmd),
        .sdrd     (sdrd),
        .sclk     (sclk),
        .sdo      (sdo),
        .phase    (phase),
        .cmd_last (cmd_last),
        .last_bit (last_bit),
        .rx_data  (rx_data)
    );

    // Starvation counter: counts CPU frames won while the poller waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (poll_start) begin
            starve_cnt <= '0;
        end else if (cpu_start & poll_req & ~starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Frame sequencing, owner tracking and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_CPU;
            aband     <= 1'b0;
            poll_gnt  <= 1'b0;
            cpu_rdata <= '0;
            poll_data <= '0;
        end else begin
            poll_gnt <= poll_start;
            if (run & (owner == OWN_CPU) & sser_n) begin
                aband <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (wr_hit) begin
                        state <= ACK;
                    end else if (start) begin
                        state <= CMD;
                        owner <= poll_start ? OWN_POLL : OWN_CPU;
                        aband <= 1'b0;
                    end
                end
                CMD: begin
                    if (phase & cmd_last) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (phase & last_bit) begin
                        state <= DONE;
                        if (owner == OWN_POLL) begin
                            poll_data <= rx_data;
                        end else if (~aband & ~sser_n) begin
                            cpu_rdata <= rx_data;
                        end
                    end
                end
                DONE: begin
                    if ((owner == OWN_CPU) & ~aband) begin
                        state <= WAIT_REL;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACK: begin
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (sser_n) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sdrd_serial_ctrl.md
Name: sdrd_serial_ctrl

Overview:
Sequences the shared serial data reader (SDRD) port between two requesters: the host bus and a background poller.
- Host bus side: decoded I/O window, SSER strobe, BR_W.
- Poller side: status poller handshake.
- Each granted request runs one fixed-length serial frame: command bits shifted out, then data bits sampled from sdrd.
- Results return to the winning requester.

Parameters:
CMD_BITS, 4, command field width shifted out MSB first (carries BA7..BA4 or poll_cmd)
DATA_BITS, 6, data field width sampled from sdrd
DIV, 2, clk cycles per serial bit; even, >=2
STARVE_LIM, 3, consecutive CPU frames with poll_req pending before the poller is forced to win

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
sser_n  in  1  bus strobe, active low
ba13  in  1  address bit 13; window requires 0
ba12  in  1  address bit 12; window requires 1
ba_cmd  in  CMD_BITS  BA7..BA4, command for CPU frames
br_w  in  1  1=read, 0=write
cpu_rdata  out  DATA_BITS  last CPU frame result
cpu_dtack  out  1  one-cycle acknowledge to bus
poll_req  in  1  poller request, level, held until poll_done
poll_cmd  in  CMD_BITS  poller command, captured at grant
poll_gnt  out  1  one-cycle pulse at poller frame start
poll_done  out  1  one-cycle pulse, poll_data valid
poll_data  out  DATA_BITS  last poller frame result
scs  out  1  serial chip select, high for the whole frame
sclk  out  1  serial clock
sdo  out  1  serial command out
sdrd  in  1  serial data in
busy  out  1  state != IDLE

Behaviour:
- hit = ~sser_n & ~ba13 & ba12.
- States and transitions:
  - IDLE:
    - CPU read hit (hit & br_w): go to CMD.
    - CPU write hit: go to ACK.
    - Otherwise, poll_req: go to CMD.
  - CMD: shifts CMD_BITS out.
  - DATA: samples DATA_BITS in.
  - DONE: one cycle.
  - ACK: one cycle, write hit only.
  - WAIT_REL: held until sser_n=1.
- Arbitration in IDLE:
  - CPU read hit beats poll_req unless starve_cnt == STARVE_LIM; in that case the poller wins.
  - starve_cnt increments on each CPU frame started while poll_req=1 (saturating).
  - starve_cnt clears when a poller frame starts.
- Frame start (IDLE->CMD edge):
  - Command is captured into the shift register: ba_cmd or poll_cmd.
  - Owner bit is recorded.
  - scs=1 from that cycle.
  - poll_gnt pulses in that cycle if the poller is the owner.
- Bit timing:
  - Each bit lasts DIV cycles.
  - sdo is valid for the whole bit.
  - sclk=0 for the first DIV/2 cycles and 1 for the last DIV/2.
  - sdrd is sampled on the last cycle of each data bit, MSB first.
- Frame length: (CMD_BITS+DATA_BITS)*DIV cycles of scs=1; the default is 20.
- DONE:
  - scs=0.
  - The owner's result register loads.
  - For the CPU: cpu_dtack=1, then go to WAIT_REL.
  - For the poller: poll_done=1, then go to IDLE.
- Write hit: no frame; cpu_dtack pulses in the ACK cycle, then WAIT_REL.
- Latency from hit sampled in IDLE:
  - Read: cpu_dtack is asserted 1+20 cycles later.
  - Write: cpu_dtack is asserted 1 cycle later.
- Strobe abandoned mid-frame (sser_n=1 before DONE):
  - Frame always completes; the device cannot abort.
  - cpu_dtack is suppressed and cpu_rdata is unchanged.
  - Next state is IDLE.
- poll_req dropped before grant: no frame. poll_req dropped during its frame: frame completes, and poll_done/poll_data still update.
- Reset values:
  - state IDLE, scs=0, sclk=0, sdo=0.
  - cpu_dtack=0, poll_gnt=0, poll_done=0.
  - cpu_rdata=0, poll_data=0, starve_cnt=0, busy=0.
- Reset mid-frame: all of the above on the next edge; the frame is aborted and scs drops.
- cpu_rdata and poll_data hold until overwritten by their own owner's frame.

Decomposition:
- Package sdrd_pkg:
  - state enum (IDLE, CMD, DATA, DONE, ACK, WAIT_REL).
  - owner enum (OWN_CPU, OWN_POLL).
  - window constants WIN_BA13=0, WIN_BA12=1.
  - default CMD_BITS/DATA_BITS.
- Sub-module sdrd_shift: bit timer (DIV counter), bit counter, command shift-out, data shift-in, sclk/sdo generation. It has start/phase/last_bit strobes.
- The controller holds the FSM, arbitration and the starvation counter.

Test Plan:
- CPU read, ba_cmd=4'hA, device returns 6'b101101 → sdo=1,0,1,0; cpu_dtack at cycle 21 after hit; cpu_rdata=6'h2D; WAIT_REL until sser_n=1.
- CPU write hit (br_w=0) → cpu_dtack next cycle, scs never rises, busy until sser_n=1.
- Poller alone, poll_cmd=4'h3, device 6'h15 → poll_gnt at start, poll_done after 20 scs cycles, poll_data=6'h15, cpu_rdata unchanged.
- Continuous poll_req with back-to-back CPU reads → 3 CPU frames, then a poller frame wins despite a CPU hit; starve_cnt=0 afterwards.
- sser_n released at cycle 8 of a CPU frame → frame runs the full 20 cycles, no cpu_dtack, cpu_rdata unchanged, back to IDLE.
- rst asserted at cycle 10 of a frame → next edge: scs=0, sclk=0, busy=0, all outputs at reset values; a new hit then starts a clean frame.
